// File: rtl/cnt_popcount_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cnt_popcount_seq                                                |
// | Purpose  : Sequential population counter. Accepts a depth-bit word over a  |
// |            valid/ready handshake, counts chunk bits per BUSY cycle through |
// |            one small combinational compressor, and presents the binary    |
// |            count over a valid/ready output handshake.                     |
// | Ports    : clk_i        rising-edge clock                                  |
// |            rst_ni       asynchronous active-low reset                      |
// |            in_valid_i   input word valid                                   |
// |            in_ready_o   block can accept a word                            |
// |            in_data_i    word to count (depth bits)                         |
// |            accum_i      add to previous result (optional feature only)     |
// |            out_valid_o  result valid                                       |
// |            out_ready_i  consumer accepts result                            |
// |            out_cnt_o    number of ones in the accepted word                |
// |            busy_o       high while counting                                |
// | Option   : `define CNT_POPCOUNT_ACCUM_EN adds accum_i and widens the        |
// |            accumulator by 8 bits with saturation at all-ones.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cnt_popcount_seq #(
  parameter  int depth    = 16,
  parameter  int chunk    = 4,
  localparam int cntWidth = $clog2(depth + 1),
`ifdef CNT_POPCOUNT_ACCUM_EN
  localparam int AccWidth = cntWidth + 8
`else
  localparam int AccWidth = cntWidth
`endif
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [depth-1:0]    in_data_i,
`ifdef CNT_POPCOUNT_ACCUM_EN
  input  logic                accum_i,
`endif
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [AccWidth-1:0] out_cnt_o,
  output logic                busy_o
);

  localparam int NBEATS    = (depth + chunk - 1) / chunk;
  // Shift register spans whole beats so the last beat reads zero padding.
  localparam int ShiftW    = NBEATS * chunk;
  localparam int BeatW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int PcW       = $clog2(chunk + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ShiftW-1:0]   shift_q, shift_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic [AccWidth-1:0] count_q, count_d;
  logic                out_valid_q, out_valid_d;

  logic [PcW-1:0]      beat_pc;
  logic [AccWidth:0]   count_sum;
  logic [ShiftW-1:0]   shift_load;
  logic                accept;
  logic                keep_count;

  // Per-beat compressor: ones in the low chunk bits of the shift register.
  always_comb begin
    beat_pc = '0;
    for (int i = 0; i < chunk; i++) begin
      beat_pc = beat_pc + PcW'(shift_q[i]);
    end
  end

  // One spare carry bit; it can only be set when the widened accumulator
  // is in use, in which case the result clamps to all-ones.
  assign count_sum = {1'b0, count_q} + {{(AccWidth + 1 - PcW){1'b0}}, beat_pc};

  always_comb begin
    shift_load                = '0;
    shift_load[depth-1:0]     = in_data_i;
  end

`ifdef CNT_POPCOUNT_ACCUM_EN
  assign keep_count = accum_i;
`else
  assign keep_count = 1'b0;
`endif

  // In DONE the ready is a pass-through of the consumer ready, which is
  // what allows a new word to be taken in the same cycle the result leaves.
  assign in_ready_o = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    beat_d      = beat_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
      end
      S_BUSY: begin
        count_d = count_sum[AccWidth] ? '1 : count_sum[AccWidth-1:0];
        shift_d = shift_q >> chunk;
        if (beat_q == '0) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else begin
          beat_d = beat_q - BeatW'(1);
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Accept overrides the per-state defaults (covers IDLE and DONE).
    if (accept) begin
      shift_d     = shift_load;
      count_d     = keep_count ? count_q : '0;
      beat_d      = BeatW'(NBEATS - 1);
      state_d     = S_BUSY;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      beat_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      beat_q      <= beat_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_cnt_o   = count_q;
  assign busy_o      = (state_q == S_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_cnt_popcount_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cnt_popcount_seq                                             |
// | Purpose  : Self-checking bench for cnt_popcount_seq. Directed words,       |
// |            backpressure, back-to-back accept, mid-BUSY reset and random    |
// |            words against a popcount reference; a second instance uses a   |
// |            chunk that does not divide depth.                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_cnt_popcount_seq;

  localparam int DEPTH  = 16;
  localparam int CHUNK  = 4;
  localparam int CHUNK3 = 3;
  localparam int NB     = (DEPTH + CHUNK - 1) / CHUNK;
  localparam int NB3    = (DEPTH + CHUNK3 - 1) / CHUNK3;
`ifdef CNT_POPCOUNT_ACCUM_EN
  localparam int OW     = $clog2(DEPTH + 1) + 8;
`else
  localparam int OW     = $clog2(DEPTH + 1);
`endif
  localparam int MAXV   = (1 << OW) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready, busy;
  logic [DEPTH-1:0] in_data;
  logic [OW-1:0]    out_cnt;
  logic             in_valid3, in_ready3, out_valid3, out_ready3, busy3;
  logic [DEPTH-1:0] in_data3;
  logic [OW-1:0]    out_cnt3;
`ifdef CNT_POPCOUNT_ACCUM_EN
  logic             accum;
`endif

  int checks = 0;
  int errors = 0;
  int prev_res = 0;

  always #5 clk = ~clk;

  cnt_popcount_seq #(.depth(DEPTH), .chunk(CHUNK)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
`ifdef CNT_POPCOUNT_ACCUM_EN
    .accum_i    (accum),
`endif
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_cnt_o  (out_cnt),
    .busy_o     (busy)
  );

  cnt_popcount_seq #(.depth(DEPTH), .chunk(CHUNK3)) dut3 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid3),
    .in_ready_o (in_ready3),
    .in_data_i  (in_data3),
`ifdef CNT_POPCOUNT_ACCUM_EN
    .accum_i    (1'b0),
`endif
    .out_valid_o(out_valid3),
    .out_ready_i(out_ready3),
    .out_cnt_o  (out_cnt3),
    .busy_o     (busy3)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: count of ones, optionally added to the previous result,
  // clamped to the output range.
  function automatic int model(input logic [DEPTH-1:0] d, input bit acc, input int prev);
    int r;
    r = $countones(d);
    if (acc) r = r + prev;
    if (r > MAXV) r = MAXV;
    return r;
  endfunction

  // Waits for the result of a word accepted on the previous edge and checks
  // latency, BUSY length and value.
  task automatic wait_result(input string tag, input int exp);
    int nb;
    int lat;
    nb  = 0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (busy) nb++;
      step;
      lat++;
    end
    check({tag, "_latency"}, lat, NB + 1);
    check({tag, "_busy_cycles"}, nb, NB);
    check({tag, "_cnt"}, int'(out_cnt), exp);
    check({tag, "_busy_in_done"}, int'(busy), 0);
  endtask

  task automatic run_word(input string tag, input logic [DEPTH-1:0] d, input bit acc,
                          input int hold);
    int n;
    int exp;
    bit a;
`ifdef CNT_POPCOUNT_ACCUM_EN
    a     = acc;
    accum = acc;
`else
    a = 1'b0 & acc;
`endif
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      step;
      n++;
    end
    check({tag, "_in_ready"}, int'(in_ready), 1);
    step;
    in_valid = 1'b0;
    in_data  = DEPTH'($urandom);
`ifdef CNT_POPCOUNT_ACCUM_EN
    accum = 1'($urandom);
`endif
    exp      = model(d, a, prev_res);
    prev_res = exp;
    wait_result(tag, exp);
    for (int i = 0; i < hold; i++) begin
      step;
      check({tag, "_hold_valid"}, int'(out_valid), 1);
      check({tag, "_hold_cnt"}, int'(out_cnt), exp);
      check({tag, "_hold_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    check({tag, "_ready_passthru"}, int'(in_ready), 1);
    step;
    out_ready = 1'b0;
    check({tag, "_valid_cleared"}, int'(out_valid), 0);
  endtask

  initial begin
    int exp;
    int nb;
    int n;
    logic [DEPTH-1:0] d;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    in_valid3  = 1'b0;
    in_data3   = '0;
    out_ready3 = 1'b1;
`ifdef CNT_POPCOUNT_ACCUM_EN
    accum      = 1'b0;
`endif
    repeat (3) step;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_cnt", int'(out_cnt), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    step;

    run_word("ffff", 16'hFFFF, 1'b0, 0);
    run_word("zero", 16'h0000, 1'b0, 0);
    run_word("8001", 16'h8001, 1'b0, 1);
    run_word("a5a5", 16'hA5A5, 1'b0, 0);

    // Backpressure for 10 cycles, then release together with a new word.
    in_valid = 1'b1;
    in_data  = 16'h1234;
    step;
    in_valid = 1'b0;
    in_data  = '1;
    prev_res = model(16'h1234, 1'b0, 0);
    wait_result("bp", prev_res);
    for (int i = 0; i < 10; i++) begin
      step;
      check("bp_valid", int'(out_valid), 1);
      check("bp_cnt", int'(out_cnt), prev_res);
      check("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0F0F;
    #1;
    check("b2b_in_ready", int'(in_ready), 1);
    step;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    check("b2b_busy", int'(busy), 1);
    check("b2b_valid_low", int'(out_valid), 0);
    prev_res = model(16'h0F0F, 1'b0, 0);
    wait_result("b2b", prev_res);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;

    // Reset during the second BUSY cycle.
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    step;
    in_valid = 1'b0;
    step;
    check("mid_busy_before_rst", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", int'(busy), 0);
    check("mrst_valid", int'(out_valid), 0);
    check("mrst_in_ready", int'(in_ready), 1);
    check("mrst_cnt", int'(out_cnt), 0);
    step;
    rst_n    = 1'b1;
    prev_res = 0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step;
      if (out_valid || busy) n++;
    end
    check("mrst_no_stale", n, 0);
    run_word("post_rst", 16'h0003, 1'b0, 0);

`ifdef CNT_POPCOUNT_ACCUM_EN
    run_word("acc_base", 16'hFFFF, 1'b0, 0);
    run_word("acc_add", 16'h00FF, 1'b1, 0);
    check("acc_24", prev_res, 24);
`endif

    for (int k = 0; k < 20; k++) begin
      run_word("rand", DEPTH'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    // Second instance: chunk does not divide depth, last beat is padded.
    for (int k = 0; k < 5; k++) begin
      d = (k == 0) ? 16'hFFFF : DEPTH'($urandom);
      check("c3_in_ready", int'(in_ready3), 1);
      in_valid3 = 1'b1;
      in_data3  = d;
      step;
      in_valid3 = 1'b0;
      in_data3  = DEPTH'($urandom);
      nb = 0;
      n  = 0;
      while (!out_valid3 && n < 100) begin
        if (busy3) nb++;
        step;
        n++;
      end
      exp = $countones(d);
      check("c3_busy_cycles", nb, NB3);
      check("c3_cnt", int'(out_cnt3), exp);
      step;
      check("c3_valid_cleared", int'(out_valid3), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cnt_popcount_seq.md
Name: cnt_popcount_seq

Overview:
- Sequential (m,k)-counter: accepts a depth-bit word over a valid/ready handshake and returns its population count as a binary result.
- Reduces chunk bits per cycle through one combinational slice-style compressor. The running binary count is held in an accumulator register.
- Consumer end of the counter-slice datapath: it takes the bits those slices compress and resolves them into a binary result. It is used where a full-width combinational counter tree is too large.

Parameters:
- depth, 16, number of input bits (>= 2)
- chunk, 4, input bits counted per BUSY cycle (1 <= chunk <= depth)
- cntWidth, log2floor(depth)+1 (derived localparam, not overridable), result width

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- in_valid_i  input  1  input word valid
- in_ready_o  output  1  block can accept a word
- in_data_i  input  depth  word to count
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts result
- out_cnt_o  output  cntWidth  number of ones in the accepted word
- busy_o  output  1  high while in BUSY

Behaviour:
- Reset (rst_ni low, async): state=IDLE; in_ready_o=1; out_valid_o=0; out_cnt_o=0; busy_o=0; shift register and beat counter cleared.
- States: IDLE, BUSY, DONE.
- Beats: NBEATS = ceil(depth/chunk). The last beat zero-pads the bits above depth.
- IDLE: in_ready_o=1. On in_valid_i & in_ready_o:
  - latch in_data_i into the shift register
  - count := 0
  - beat counter := NBEATS-1
  - go to BUSY
- BUSY: each cycle, count += popcount(shift[chunk-1:0]); shift >>= chunk (zero fill).
  - If beat counter == 0, go to DONE. Otherwise decrement the beat counter.
  - in_ready_o=0 and busy_o=1 throughout.
- DONE: out_valid_o=1; out_cnt_o = count, stable until the handshake completes.
  - On out_ready_i: if in_valid_i is also high, the new word is accepted in the same cycle and the state goes directly to BUSY (back-to-back). Otherwise go to IDLE.
  - in_ready_o = out_ready_i in DONE (combinational).
- Latency from input handshake to out_valid_o: NBEATS+1 cycles. Throughput: one word per NBEATS+1 cycles.
- Width rules:
  - per-beat popcount is log2floor(chunk)+1 bits, zero-extended to cntWidth
  - the accumulator never overflows, since the maximum is depth < 2^cntWidth
- out_valid_o must not drop and out_cnt_o must not change while out_valid_o=1 and out_ready_i=0.
- in_data_i is sampled only on the input handshake cycle. Later changes have no effect.
- Reset asserted mid-BUSY or in DONE: the word in flight is discarded, no result is produced, and all outputs return to reset values immediately.
- chunk == depth: NBEATS=1, so a single BUSY cycle.
- chunk == 1: NBEATS=depth.

Optional Feature:
- Macro: CNT_POPCOUNT_ACCUM_EN.
- Defined:
  - adds input port accum_i (1 bit), sampled on the input handshake
  - accum_i=1: count is not cleared and the new word's ones are added to the previous result
  - the accumulator widens to cntWidth+8 bits; out_cnt_o widens accordingly and saturates at all-ones
  - reset clears the accumulator
- Undefined: no accum_i port; count is cleared on every accepted word; out_cnt_o is cntWidth bits.

Test Plan:
- depth=16, chunk=4, in_data_i=16'hFFFF, out_ready_i=1 -> busy_o high 4 cycles; out_cnt_o=16 with out_valid_o on cycle 5 after the handshake.
- in_data_i=16'h0000 -> out_cnt_o=0. in_data_i=16'h8001 -> out_cnt_o=2. in_data_i=16'hA5A5 -> out_cnt_o=8.
- depth=16, chunk=3, in_data_i=16'hFFFF -> 6 BUSY cycles (padded last beat); out_cnt_o=16.
- Backpressure: hold out_ready_i=0 for 10 cycles in DONE -> out_valid_o=1 and out_cnt_o stable, in_ready_o=0. Then assert out_ready_i together with in_valid_i (16'h0F0F) -> same-cycle accept, BUSY next cycle, next out_cnt_o=8.
- Drop rst_ni during the 2nd BUSY cycle -> outputs reset immediately; after release no stale out_valid_o; next word 16'h0003 -> out_cnt_o=2.
- With CNT_POPCOUNT_ACCUM_EN: 16'hFFFF (accum_i=0), then 16'h00FF (accum_i=1) -> results 16 then 24.
